// File: rtl/pf_reset_seq_pkg.sv
// Shared types and constants for the PolarFire init reset sequencer.
//   seq_state_e : sequencer state encoding (also exported on SEQ_STATE)
//   MASK_*      : bit positions inside INIT_MASK / the done-flag vector
//   LOSS_CNT_W  : width of the lock-loss event counter
//   cnt_width() : counter width for a given limit, never below 1 bit
package pf_reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_INIT = 3'd1,
    ST_DEBOUNCE  = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } seq_state_e;

  localparam int unsigned MASK_SRAM      = 0;
  localparam int unsigned MASK_USRAM     = 1;
  localparam int unsigned MASK_XCVR      = 2;
  localparam int unsigned MASK_AUTOCALIB = 3;
  localparam int unsigned INIT_FLAG_W    = 4;

  localparam int unsigned LOSS_CNT_W = 8;

  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/pf_sync_bit.sv
// Single-bit multi-flop synchronizer with synchronous active-high reset to 0.
//   clk   : destination clock
//   reset : synchronous, active-high; clears every stage
//   d     : asynchronous input
//   q     : synchronized output, STAGES cycles behind d
module pf_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pf_init_reset_seq.sv
// Staged fabric reset sequencer driven by the PolarFire init monitor.
// Synchronizes the init flags, PLL lock and external reset request, waits for
// a debounced ready condition, then releases STAGE_RESET_N bit by bit.
// Any loss of ready after debounce starts drops every reset at once.
//   CLK, RESET        : system clock, synchronous active-high reset
//   FABRIC_POR_N .. EXT_RST_N : asynchronous status / request inputs
//   STAGE_RESET_N     : staged active-low resets, bit 0 released first
//   FABRIC_RESET_N    : high only in RUN
//   SEQ_STATE         : current state, debug
//   LOCK_LOSS_CNT     : saturating count of faults taken from RUN
//   INIT_TIMEOUT      : sticky init timeout flag
// Build option: define INIT_TIMEOUT_EN to build the WAIT_INIT timeout
// counter; without it INIT_TIMEOUT is tied low.
module pf_init_reset_seq
  import pf_reset_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 256,
  parameter int unsigned NUM_STAGES      = 3,
  parameter int unsigned STAGE_GAP       = 16,
  parameter logic [3:0]  INIT_MASK       = 4'b1111,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FABRIC_POR_N,
  input  logic                  DEVICE_INIT_DONE,
  input  logic                  SRAM_INIT_DONE,
  input  logic                  USRAM_INIT_DONE,
  input  logic                  XCVR_INIT_DONE,
  input  logic                  AUTOCALIB_DONE,
  input  logic                  PLL_LOCK,
  input  logic                  EXT_RST_N,
  output logic [NUM_STAGES-1:0] STAGE_RESET_N,
  output logic                  FABRIC_RESET_N,
  output logic [2:0]            SEQ_STATE,
  output logic [LOSS_CNT_W-1:0] LOCK_LOSS_CNT,
  output logic                  INIT_TIMEOUT
);

  localparam int unsigned NS     = NUM_STAGES;
  localparam int unsigned DEB_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned GAP_W  = cnt_width(STAGE_GAP);
  localparam int unsigned STG_W  = cnt_width(NUM_STAGES);
  localparam int unsigned N_SYNC = 8;

  // Input synchronizers: 0 por, 1 dev, 2 sram, 3 usram, 4 xcvr, 5 acal, 6 lock, 7 ext
  logic [N_SYNC-1:0] async_in;
  logic [N_SYNC-1:0] sync_s;

  assign async_in = {EXT_RST_N, PLL_LOCK, AUTOCALIB_DONE, XCVR_INIT_DONE,
                     USRAM_INIT_DONE, SRAM_INIT_DONE, DEVICE_INIT_DONE, FABRIC_POR_N};

  for (genvar i = 0; i < N_SYNC; i++) begin : g_sync
    pf_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (CLK),
      .reset (RESET),
      .d     (async_in[i]),
      .q     (sync_s[i])
    );
  end

  // Ready qualification: unmasked done flags are treated as always done
  logic [INIT_FLAG_W-1:0] done_vec_s;
  logic                   ready;

  assign done_vec_s[MASK_SRAM]      = sync_s[2];
  assign done_vec_s[MASK_USRAM]     = sync_s[3];
  assign done_vec_s[MASK_XCVR]      = sync_s[4];
  assign done_vec_s[MASK_AUTOCALIB] = sync_s[5];

  assign ready = sync_s[0] & sync_s[1] & sync_s[6] & sync_s[7]
               & (&(done_vec_s | ~INIT_MASK));

  // Sequencer state and registered outputs
  seq_state_e            state_q, state_d;
  logic [DEB_W-1:0]      deb_cnt_q, deb_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [STG_W-1:0]      stage_idx_q, stage_idx_d;
  logic [NS-1:0]         stage_rst_q, stage_rst_d;
  logic                  fabric_q, fabric_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic [STG_W-1:0]      nxt_idx;
  logic                  fault;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      deb_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      stage_idx_q <= '0;
      stage_rst_q <= '0;
      fabric_q    <= 1'b0;
      loss_q      <= '0;
    end else begin
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      stage_idx_q <= stage_idx_d;
      stage_rst_q <= stage_rst_d;
      fabric_q    <= fabric_d;
      loss_q      <= loss_d;
    end
  end

  // Next-state logic; a fault overrides any debounce completion or stage step
  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    stage_idx_d = stage_idx_q;
    stage_rst_d = stage_rst_q;
    fabric_d    = fabric_q;
    loss_d      = loss_q;
    nxt_idx     = stage_idx_q + STG_W'(1);
    fault       = ~ready & (state_q inside {ST_DEBOUNCE, ST_RELEASE, ST_RUN});

    if (fault) begin
      state_d     = ST_WAIT_INIT;
      deb_cnt_d   = '0;
      gap_cnt_d   = '0;
      stage_idx_d = '0;
      stage_rst_d = '0;
      fabric_d    = 1'b0;
      if (state_q == ST_RUN && loss_q != {LOSS_CNT_W{1'b1}}) begin
        loss_d = loss_q + LOSS_CNT_W'(1);
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_WAIT_INIT;
          deb_cnt_d   = '0;
          gap_cnt_d   = '0;
          stage_idx_d = '0;
          stage_rst_d = '0;
          fabric_d    = 1'b0;
        end
        ST_WAIT_INIT: begin
          deb_cnt_d = '0;
          if (ready) begin
            state_d = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_cnt_d   = '0;
            gap_cnt_d   = '0;
            stage_idx_d = '0;
            stage_rst_d = NS'(1);
            // A single stage is already fully released on entry
            if (NUM_STAGES == 1) begin
              state_d  = ST_RUN;
              fabric_d = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
          end
        end
        ST_RELEASE: begin
          if (gap_cnt_q == GAP_W'(STAGE_GAP - 1)) begin
            gap_cnt_d   = '0;
            stage_idx_d = nxt_idx;
            stage_rst_d = stage_rst_q | (NS'(1) << nxt_idx);
            if (nxt_idx == STG_W'(NUM_STAGES - 1)) begin
              state_d  = ST_RUN;
              fabric_d = 1'b1;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
        ST_RUN: begin
          fabric_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign STAGE_RESET_N  = stage_rst_q;
  assign FABRIC_RESET_N = fabric_q;
  assign SEQ_STATE      = state_q;
  assign LOCK_LOSS_CNT  = loss_q;

`ifdef INIT_TIMEOUT_EN
  localparam int unsigned TMO_W = cnt_width(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_q;

  // Timeout counter runs only in WAIT_INIT and holds at its limit; flag is sticky
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else if (state_q == ST_WAIT_INIT) begin
      if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        tmo_q <= 1'b1;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
      end
    end else begin
      tmo_cnt_q <= '0;
    end
  end

  assign INIT_TIMEOUT = tmo_q;
`else
  assign INIT_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_pf_init_reset_seq.sv
// Scoreboard bench for pf_init_reset_seq: stimulus schedules expected output
// snapshots at absolute cycle numbers, a negedge monitor pops and compares.
// dut uses INIT_MASK=1111; dut_m uses INIT_MASK=0011 with XCVR/AUTOCALIB low.
module tb_pf_init_reset_seq;

  localparam int unsigned NS = 3;

`ifdef INIT_TIMEOUT_EN
  localparam logic TMO_ON = 1'b1;
`else
  localparam logic TMO_ON = 1'b0;
`endif

  localparam logic [3:0] S_RST   = 4'd0;
  localparam logic [3:0] S_NOM   = 4'd1;
  localparam logic [3:0] S_MASK  = 4'd2;
  localparam logic [3:0] S_LOSS  = 4'd3;
  localparam logic [3:0] S_SAT   = 4'd4;
  localparam logic [3:0] S_MID   = 4'd5;
  localparam logic [3:0] S_GLT   = 4'd6;
  localparam logic [3:0] S_TMO   = 4'd7;

  typedef struct packed {
    logic [31:0] cyc;
    logic        sel;
    logic [3:0]  scen;
    logic [2:0]  stage;
    logic        fab;
    logic [2:0]  st;
    logic [7:0]  loss;
    logic        tmo;
  } exp_t;

  logic CLK, RESET;
  logic por_n, dev_done, sram_done, usram_done, xcvr_done, acal_done, pll_lock, ext_rst_n;
  logic xcvr_m, acal_m;
  logic [NS-1:0] stage_n, m_stage_n;
  logic fab_n, m_fab_n, tmo, m_tmo;
  logic [2:0] seq_st, m_seq_st;
  logic [7:0] loss, m_loss;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  exp_t exp_q[$];
  exp_t cur;
  logic [15:0] act, want;

  pf_init_reset_seq #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .NUM_STAGES(NS), .STAGE_GAP(4),
    .INIT_MASK(4'b1111), .TIMEOUT_CYCLES(32)
  ) dut (
    .CLK(CLK), .RESET(RESET), .FABRIC_POR_N(por_n), .DEVICE_INIT_DONE(dev_done),
    .SRAM_INIT_DONE(sram_done), .USRAM_INIT_DONE(usram_done),
    .XCVR_INIT_DONE(xcvr_done), .AUTOCALIB_DONE(acal_done), .PLL_LOCK(pll_lock),
    .EXT_RST_N(ext_rst_n), .STAGE_RESET_N(stage_n), .FABRIC_RESET_N(fab_n),
    .SEQ_STATE(seq_st), .LOCK_LOSS_CNT(loss), .INIT_TIMEOUT(tmo)
  );

  pf_init_reset_seq #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .NUM_STAGES(NS), .STAGE_GAP(4),
    .INIT_MASK(4'b0011), .TIMEOUT_CYCLES(32)
  ) dut_m (
    .CLK(CLK), .RESET(RESET), .FABRIC_POR_N(por_n), .DEVICE_INIT_DONE(dev_done),
    .SRAM_INIT_DONE(sram_done), .USRAM_INIT_DONE(usram_done),
    .XCVR_INIT_DONE(xcvr_m), .AUTOCALIB_DONE(acal_m), .PLL_LOCK(pll_lock),
    .EXT_RST_N(ext_rst_n), .STAGE_RESET_N(m_stage_n), .FABRIC_RESET_N(m_fab_n),
    .SEQ_STATE(m_seq_st), .LOCK_LOSS_CNT(m_loss), .INIT_TIMEOUT(m_tmo)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic string scen_name(input logic [3:0] s);
    case (s)
      S_RST:   return "reset_values";
      S_NOM:   return "nominal_release";
      S_MASK:  return "init_mask";
      S_LOSS:  return "lock_loss_run";
      S_SAT:   return "lock_loss_saturate";
      S_MID:   return "reset_mid_release";
      S_GLT:   return "debounce_glitch";
      S_TMO:   return "init_timeout";
      default: return "unknown";
    endcase
  endfunction

  // Insert keeping the queue ordered by cycle
  function automatic void expect_at(input int c, input logic sel, input logic [3:0] scen,
                                    input logic [2:0] stage, input logic fab,
                                    input logic [2:0] st, input logic [7:0] lc,
                                    input logic tm);
    exp_t e;
    int pos;
    e = '{cyc: 32'(c), sel: sel, scen: scen, stage: stage, fab: fab, st: st, loss: lc, tmo: tm};
    pos = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (int'(exp_q[i].cyc) > c) begin
        pos = i;
        break;
      end
    end
    exp_q.insert(pos, e);
  endfunction

  // Monitor: compare every expectation due at or before the current cycle
  always @(negedge CLK) begin
    while (exp_q.size() != 0 && int'(exp_q[0].cyc) <= cyc) begin
      cur  = exp_q.pop_front();
      act  = cur.sel ? {m_stage_n, m_fab_n, m_seq_st, m_loss, m_tmo}
                     : {stage_n, fab_n, seq_st, loss, tmo};
      want = {cur.stage, cur.fab, cur.st, cur.loss, cur.tmo};
      n_checks++;
      if (int'(cur.cyc) == cyc && act == want) begin
        n_pass++;
      end else begin
        $display("FAIL %s dut%0d cyc %0d (due %0d): got stage=%b fab=%b st=%0d loss=%0d tmo=%b, required stage=%b fab=%b st=%0d loss=%0d tmo=%b",
                 scen_name(cur.scen), cur.sel, cyc, cur.cyc, act[15:13], act[12], act[11:9],
                 act[8:1], act[0], want[15:13], want[12], want[11:9], want[8:1], want[0]);
      end
    end
  end

  // Assert RESET for two edges, expecting all-zero outputs after the first
  task automatic do_reset(output int c);
    RESET = 1'b1;
    expect_at(cyc + 1, 1'b0, S_RST, 3'b000, 1'b0, 3'd0, 8'd0, 1'b0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    c = cyc;
  endtask

  initial begin
    int c, d, sat;
    RESET = 1'b1;
    por_n = 1'b1; dev_done = 1'b1; sram_done = 1'b1; usram_done = 1'b1;
    xcvr_done = 1'b1; acal_done = 1'b1; pll_lock = 1'b1; ext_rst_n = 1'b1;
    xcvr_m = 1'b0; acal_m = 1'b0;
    repeat (3) @(negedge CLK);

    // Nominal release; masked instance must follow the same timeline
    do_reset(c);
    expect_at(c + 1,  1'b0, S_NOM, 3'b000, 1'b0, 3'd1, 8'd0, 1'b0);
    expect_at(c + 3,  1'b0, S_NOM, 3'b000, 1'b0, 3'd2, 8'd0, 1'b0);
    expect_at(c + 10, 1'b0, S_NOM, 3'b000, 1'b0, 3'd2, 8'd0, 1'b0);
    expect_at(c + 11, 1'b0, S_NOM, 3'b001, 1'b0, 3'd3, 8'd0, 1'b0);
    expect_at(c + 14, 1'b0, S_NOM, 3'b001, 1'b0, 3'd3, 8'd0, 1'b0);
    expect_at(c + 15, 1'b0, S_NOM, 3'b011, 1'b0, 3'd3, 8'd0, 1'b0);
    expect_at(c + 18, 1'b0, S_NOM, 3'b011, 1'b0, 3'd3, 8'd0, 1'b0);
    expect_at(c + 19, 1'b0, S_NOM, 3'b111, 1'b1, 3'd4, 8'd0, 1'b0);
    expect_at(c + 11, 1'b1, S_MASK, 3'b001, 1'b0, 3'd3, 8'd0, 1'b0);
    expect_at(c + 19, 1'b1, S_MASK, 3'b111, 1'b1, 3'd4, 8'd0, 1'b0);
    repeat (20) @(negedge CLK);

    // Lock loss in RUN, then recovery
    d = cyc;
    pll_lock = 1'b0;
    expect_at(d + 2, 1'b0, S_LOSS, 3'b111, 1'b1, 3'd4, 8'd0, 1'b0);
    expect_at(d + 3, 1'b0, S_LOSS, 3'b000, 1'b0, 3'd1, 8'd1, 1'b0);
    repeat (3) @(negedge CLK);
    pll_lock = 1'b1;
    expect_at(d + 14, 1'b0, S_LOSS, 3'b001, 1'b0, 3'd3, 8'd1, 1'b0);
    expect_at(d + 22, 1'b0, S_LOSS, 3'b111, 1'b1, 3'd4, 8'd1, 1'b0);
    repeat (20) @(negedge CLK);

    // Repeated lock loss: counter saturates at 255
    for (int n = 2; n <= 300; n++) begin
      sat = (n > 255) ? 255 : n;
      d = cyc;
      pll_lock = 1'b0;
      expect_at(d + 3, 1'b0, S_SAT, 3'b000, 1'b0, 3'd1, 8'(sat), 1'b0);
      repeat (3) @(negedge CLK);
      pll_lock = 1'b1;
      expect_at(d + 22, 1'b0, S_SAT, 3'b111, 1'b1, 3'd4, 8'(sat), 1'b0);
      repeat (20) @(negedge CLK);
    end

    // RESET while STAGE_RESET_N = 011 clears everything including the counter
    d = cyc;
    pll_lock = 1'b0;
    expect_at(d + 3, 1'b0, S_MID, 3'b000, 1'b0, 3'd1, 8'd255, 1'b0);
    repeat (3) @(negedge CLK);
    pll_lock = 1'b1;
    expect_at(d + 18, 1'b0, S_MID, 3'b011, 1'b0, 3'd3, 8'd255, 1'b0);
    expect_at(d + 19, 1'b0, S_MID, 3'b011, 1'b0, 3'd3, 8'd255, 1'b0);
    repeat (16) @(negedge CLK);
    do_reset(c);

    // One-cycle PLL glitch at debounce count 5
    expect_at(c + 8,  1'b0, S_GLT, 3'b000, 1'b0, 3'd2, 8'd0, 1'b0);
    expect_at(c + 9,  1'b0, S_GLT, 3'b000, 1'b0, 3'd1, 8'd0, 1'b0);
    expect_at(c + 10, 1'b0, S_GLT, 3'b000, 1'b0, 3'd2, 8'd0, 1'b0);
    expect_at(c + 17, 1'b0, S_GLT, 3'b000, 1'b0, 3'd2, 8'd0, 1'b0);
    expect_at(c + 18, 1'b0, S_GLT, 3'b001, 1'b0, 3'd3, 8'd0, 1'b0);
    expect_at(c + 26, 1'b0, S_GLT, 3'b111, 1'b1, 3'd4, 8'd0, 1'b0);
    repeat (6) @(negedge CLK);
    pll_lock = 1'b0;
    @(negedge CLK);
    pll_lock = 1'b1;
    repeat (20) @(negedge CLK);

    // Init timeout with SRAM_INIT_DONE held low
    sram_done = 1'b0;
    do_reset(c);
    expect_at(c + 2,  1'b0, S_TMO, 3'b000, 1'b0, 3'd1, 8'd0, 1'b0);
    expect_at(c + 32, 1'b0, S_TMO, 3'b000, 1'b0, 3'd1, 8'd0, 1'b0);
    expect_at(c + 33, 1'b0, S_TMO, 3'b000, 1'b0, 3'd1, 8'd0, TMO_ON);
    repeat (40) @(negedge CLK);
    sram_done = 1'b1;
    expect_at(c + 51, 1'b0, S_TMO, 3'b001, 1'b0, 3'd3, 8'd0, TMO_ON);
    expect_at(c + 59, 1'b0, S_TMO, 3'b111, 1'b1, 3'd4, 8'd0, TMO_ON);
    repeat (20) @(negedge CLK);

    // RESET clears the sticky timeout
    do_reset(c);

    n_checks++;
    if (stage_n == 3'b000) n_pass++;
    else $display("FAIL reset_values: STAGE_RESET_N=%b after RESET", stage_n);
    n_checks++;
    if (seq_st == 3'd0) n_pass++;
    else $display("FAIL reset_values: SEQ_STATE=%0d after RESET", seq_st);
    n_checks++;
    if (loss == 8'd0) n_pass++;
    else $display("FAIL reset_values: LOCK_LOSS_CNT=%0d after RESET", loss);
    n_checks++;
    if (tmo == 1'b0) n_pass++;
    else $display("FAIL reset_values: INIT_TIMEOUT=%b after RESET", tmo);
    n_checks++;
    if (m_stage_n == 3'b000 && m_fab_n == 1'b0) n_pass++;
    else $display("FAIL reset_values: masked STAGE_RESET_N=%b FABRIC_RESET_N=%b after RESET",
                  m_stage_n, m_fab_n);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge CLK);
    while (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      n_checks++;
      $display("FAIL %s never checked: due cyc %0d, now %0d", scen_name(cur.scen), cur.cyc, cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
